unique_compactor: RTL and testbench

UNIQUE_COMPACTOR -- requirements
Module: unique_compactor

---
 rtl/unique_compactor.sv | 211 +++++++++++++++++++++
 tb/tb_unique_compactor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/unique_compactor.sv
// unique_compactor
//   Buffers groups of GROUP_SIZE elements in an input FIFO. While a job is
//   running, it pops one group per accepted cycle. For each group it emits the
//   distinct elements in order of first occurrence, a per-element index map
//   into those slots, and the unique count. A job is num_iters iterations of
//   num_reads_per_iter reads each.
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   configure              load job counts and bypass (any state)
//   num_iters              iterations per job
//   num_reads_per_iter     pops per iteration
//   bypass                 pass groups through without deduplication
//   data_in, valid_in      input group (element i at [i*DATA_WIDTH +: DATA_WIDTH])
//   avail_out              at least two FIFO slots free
//   data_out               compacted uniques; unused slots are zero
//   idx_map                per-element slot index (element i at [i*IDX_W +: IDX_W])
//   num_unique             number of valid slots in data_out
//   valid_out              one-cycle strobe for a new result
//   avail_in               downstream can accept a result next cycle
//   done                   end-of-job pulse
//   overflow               sticky: a group arrived while the FIFO was full
module unique_compactor #(
   parameter int unsigned GROUP_SIZE             = 4,
   parameter int unsigned DATA_WIDTH             = 8,
   parameter int unsigned FIFO_DEPTH             = 8,
   parameter int unsigned LOG_MAX_ITERS          = 16,
   parameter int unsigned LOG_MAX_READS_PER_ITER = 16,
   localparam int unsigned IDX_W                 = $clog2(GROUP_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             configure,
   input  logic [LOG_MAX_ITERS-1:0]          num_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
   input  logic                             bypass,
   input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
   input  logic                             valid_in,
   output logic                             avail_out,
   output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
   output logic [GROUP_SIZE*IDX_W-1:0]      idx_map,
   output logic [IDX_W:0]                   num_unique,
   output logic                             valid_out,
   input  logic                             avail_in,
   output logic                             done,
   output logic                             overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned GW = GROUP_SIZE * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                            r_state, w_state_nxt;
   logic [GW-1:0]                     r_mem [FIFO_DEPTH];
   logic [AW:0]                       r_wr_ptr, r_rd_ptr;
   logic [LOG_MAX_ITERS-1:0]          r_iters;
   logic [LOG_MAX_READS_PER_ITER-1:0] r_reads, r_reads_reload;
   logic                              r_bypass, r_done, r_overflow, r_valid_out;
   logic [GW-1:0]                     r_data_out;
   logic [GROUP_SIZE*IDX_W-1:0]       r_idx_map;
   logic [IDX_W:0]                    r_num_unique;

   logic [AW:0]                       w_count;
   logic                              w_empty, w_full, w_push, w_pop;
   logic                              w_cfg_zero, w_reads_one, w_last, w_done_nxt;
   logic [GW-1:0]                     w_head, w_cdata;
   logic [GROUP_SIZE*IDX_W-1:0]       w_cidx, w_bidx;
   logic [IDX_W:0]                    w_cnt;
   logic                              w_found;
   logic [IDX_W-1:0]                  w_slot;

   // FIFO status; pointers carry one extra wrap bit
   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign avail_out = ((32'(w_count) + 32'd2) <= FIFO_DEPTH);
   assign w_push    = valid_in && !w_full;
   assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

   assign w_cfg_zero  = (num_iters == '0) || (num_reads_per_iter == '0);
   assign w_reads_one = (r_reads == LOG_MAX_READS_PER_ITER'(1));
   assign w_last      = w_reads_one && (r_iters == LOG_MAX_ITERS'(1));
   // configure wins over a pop in the same cycle
   assign w_pop       = (r_state == S_RUN) && !w_empty && avail_in && !configure;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      if (configure) begin
         w_state_nxt = w_cfg_zero ? S_IDLE : S_RUN;
         w_done_nxt  = w_cfg_zero;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_RUN: begin
               if (w_pop && w_last) begin
                  w_state_nxt = S_DRAIN;
                  w_done_nxt  = 1'b1;
               end
            end
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (valid_in && w_full) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_iters        <= '0;
         r_reads        <= '0;
         r_reads_reload <= '0;
         r_bypass       <= 1'b0;
      end else if (configure) begin
         r_iters        <= num_iters;
         r_reads        <= num_reads_per_iter;
         r_reads_reload <= num_reads_per_iter;
         r_bypass       <= bypass;
      end else if (w_pop) begin
         if (w_reads_one) begin
            if (!w_last) begin
               r_iters <= r_iters - LOG_MAX_ITERS'(1);
               r_reads <= r_reads_reload;
            end else begin
               r_iters <= '0;
               r_reads <= '0;
            end
         end else begin
            r_reads <= r_reads - LOG_MAX_READS_PER_ITER'(1);
         end
      end
   end

   // Element i either repeats an earlier element (reuse its slot) or takes
   // the next free slot.
   always_comb begin
      w_cdata = '0;
      w_cidx  = '0;
      w_bidx  = '0;
      w_cnt   = '0;
      w_found = 1'b0;
      w_slot  = '0;
      for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
         w_bidx[i*IDX_W +: IDX_W] = IDX_W'(i);
         w_found = 1'b0;
         w_slot  = '0;
         for (int unsigned j = 0; j < i; j++) begin
            if (!w_found && (w_head[j*DATA_WIDTH +: DATA_WIDTH] ==
                             w_head[i*DATA_WIDTH +: DATA_WIDTH])) begin
               w_found = 1'b1;
               w_slot  = w_cidx[j*IDX_W +: IDX_W];
            end
         end
         if (w_found) begin
            w_cidx[i*IDX_W +: IDX_W] = w_slot;
         end else begin
            w_cidx[i*IDX_W +: IDX_W]            = w_cnt[IDX_W-1:0];
            w_cdata[w_cnt*DATA_WIDTH +: DATA_WIDTH] = w_head[i*DATA_WIDTH +: DATA_WIDTH];
            w_cnt = w_cnt + (IDX_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid_out  <= 1'b0;
         r_done       <= 1'b0;
         r_data_out   <= '0;
         r_idx_map    <= '0;
         r_num_unique <= '0;
      end else begin
         r_valid_out <= w_pop;
         r_done      <= w_done_nxt;
         if (w_pop) begin
            r_data_out   <= r_bypass ? w_head : w_cdata;
            r_idx_map    <= r_bypass ? w_bidx : w_cidx;
            r_num_unique <= r_bypass ? (IDX_W+1)'(GROUP_SIZE) : w_cnt;
         end
      end
   end

   assign data_out   = r_data_out;
   assign idx_map    = r_idx_map;
   assign num_unique = r_num_unique;
   assign valid_out  = r_valid_out;
   assign done       = r_done;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_unique_compactor.sv
module tb_unique_compactor;

   logic        clk = 1'b0;
   logic        rst;
   logic        configure;
   logic [15:0] num_iters;
   logic [15:0] num_reads_per_iter;
   logic        bypass;
   logic [31:0] data_in;
   logic        valid_in;
   logic        avail_out;
   logic [31:0] data_out;
   logic [7:0]  idx_map;
   logic [2:0]  num_unique;
   logic        valid_out;
   logic        avail_in;
   logic        done;
   logic        overflow;

   int n_chk  = 0;
   int n_fail = 0;

   unique_compactor #(
      .GROUP_SIZE(4),
      .DATA_WIDTH(8),
      .FIFO_DEPTH(8),
      .LOG_MAX_ITERS(16),
      .LOG_MAX_READS_PER_ITER(16)
   ) dut (
      .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
      .num_reads_per_iter(num_reads_per_iter), .bypass(bypass),
      .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
      .data_out(data_out), .idx_map(idx_map), .num_unique(num_unique),
      .valid_out(valid_out), .avail_in(avail_in), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pack(input logic [7:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      n_chk++; if ({valid_out, done, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {valid_out, done, overflow}); end
      n_chk++; if ({data_out, idx_map, num_unique} !== 43'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%0d expected 0", data_out, idx_map, num_unique); end
      n_chk++; if (avail_out !== 1'b1) begin n_fail++; $display("FAIL reset_avail: got %b expected 1", avail_out); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd1; bypass = 1'b0; avail_in = 1'b1;
      tick();
      configure = 1'b0;
      data_in = pack(8'd3, 8'd2, 8'd3, 8'd3); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", valid_out); end
      n_chk++; if (data_out !== 32'h00000203) begin n_fail++; $display("FAIL basic_data: got %h expected 00000203", data_out); end
      n_chk++; if (idx_map !== 8'h04) begin n_fail++; $display("FAIL basic_idx: got %h expected 04", idx_map); end
      n_chk++; if (num_unique !== 3'd2) begin n_fail++; $display("FAIL basic_num: got %0d expected 2", num_unique); end
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
      tick();
      n_chk++; if ({valid_out, done} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse_end: got %b expected 00", {valid_out, done}); end
      n_chk++; if (data_out !== 32'h00000203) begin n_fail++; $display("FAIL basic_hold: got %h expected 00000203", data_out); end
   endtask

   task automatic test_dedup();
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd2; bypass = 1'b0; avail_in = 1'b1;
      tick();
      configure = 1'b0;
      data_in = pack(8'd5, 8'd5, 8'd5, 8'd5); valid_in = 1'b1;
      tick();
      data_in = pack(8'd1, 8'd2, 8'd3, 8'd4);
      tick();
      valid_in = 1'b0;
      n_chk++; if ({valid_out, done, num_unique} !== {2'b10, 3'd1}) begin n_fail++; $display("FAIL dedup1_flags: got v=%b d=%b n=%0d expected v=1 d=0 n=1", valid_out, done, num_unique); end
      n_chk++; if ({data_out, idx_map} !== {32'h00000005, 8'h00}) begin n_fail++; $display("FAIL dedup1_data: got %h/%h expected 00000005/00", data_out, idx_map); end
      tick();
      n_chk++; if ({valid_out, done, num_unique} !== {2'b11, 3'd4}) begin n_fail++; $display("FAIL dedup2_flags: got v=%b d=%b n=%0d expected v=1 d=1 n=4", valid_out, done, num_unique); end
      n_chk++; if ({data_out, idx_map} !== {32'h04030201, 8'hE4}) begin n_fail++; $display("FAIL dedup2_data: got %h/%h expected 04030201/e4", data_out, idx_map); end
      tick();
   endtask

   task automatic test_multi_iter();
      int pulses   = 0;
      int done_cnt = 0;
      int done_at  = 0;
      logic seen   = 1'b0;
      avail_in = 1'b0;
      configure = 1'b1; num_iters = 16'd2; num_reads_per_iter = 16'd3; bypass = 1'b0;
      tick();
      configure = 1'b0;
      for (int k = 0; k < 6; k++) begin
         data_in = {4{8'(k + 1)}}; valid_in = 1'b1;
         tick();
      end
      valid_in = 1'b0;
      for (int c = 0; c < 24; c++) begin
         avail_in = (c % 2 == 0);
         tick();
         if (valid_out === 1'b1) begin
            n_chk++; if (data_out !== 32'(8'(pulses + 1))) begin n_fail++; $display("FAIL multi_data: got %h expected %h", data_out, 32'(8'(pulses + 1))); end
            pulses++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_at = pulses;
         end
      end
      n_chk++; if (pulses != 6) begin n_fail++; $display("FAIL multi_pulses: got %0d expected 6", pulses); end
      n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL multi_done_cnt: got %0d expected 1", done_cnt); end
      n_chk++; if (done_at != 6) begin n_fail++; $display("FAIL multi_done_at: got %0d expected 6", done_at); end
      // back in IDLE: a queued group must not be popped until reconfigured
      avail_in = 1'b1;
      data_in = pack(8'd9, 8'd9, 8'd7, 8'd7); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (valid_out === 1'b1) seen = 1'b1;
      end
      n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_no_pop: got %b expected 0", seen); end
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd1;
      tick();
      configure = 1'b0;
      n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL cfg_priority: got %b expected 0", valid_out); end
      tick();
      n_chk++; if ({valid_out, done, num_unique} !== {2'b11, 3'd2}) begin n_fail++; $display("FAIL queued_flags: got v=%b d=%b n=%0d expected v=1 d=1 n=2", valid_out, done, num_unique); end
      n_chk++; if ({data_out, idx_map} !== {32'h00000709, 8'h50}) begin n_fail++; $display("FAIL queued_data: got %h/%h expected 00000709/50", data_out, idx_map); end
      tick();
   endtask

   task automatic test_bypass();
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd1; bypass = 1'b1; avail_in = 1'b1;
      tick();
      configure = 1'b0;
      data_in = pack(8'd3, 8'd2, 8'd3, 8'd3); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      n_chk++; if ({valid_out, done, num_unique} !== {2'b11, 3'd4}) begin n_fail++; $display("FAIL bypass_flags: got v=%b d=%b n=%0d expected v=1 d=1 n=4", valid_out, done, num_unique); end
      n_chk++; if ({data_out, idx_map} !== {32'h03030203, 8'hE4}) begin n_fail++; $display("FAIL bypass_data: got %h/%h expected 03030203/e4", data_out, idx_map); end
      tick();
      bypass = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      avail_in = 1'b0;
      for (int k = 0; k < 8; k++) begin
         data_in = pack(8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)); valid_in = 1'b1;
         tick();
         n_chk++; if ({avail_out, overflow} !== {(k + 1 <= 6), 1'b0}) begin n_fail++; $display("FAIL fill_%0d: got avail=%b ovf=%b expected avail=%b ovf=0", k, avail_out, overflow, (k + 1 <= 6)); end
      end
      data_in = 32'hDEADBEEF;
      tick();
      valid_in = 1'b0;
      n_chk++; if ({avail_out, overflow} !== 2'b01) begin n_fail++; $display("FAIL overflow_set: got avail=%b ovf=%b expected avail=0 ovf=1", avail_out, overflow); end
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd8; avail_in = 1'b1;
      tick();
      configure = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         exp = pack(8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4));
         n_chk++; if ({valid_out, done, data_out} !== {1'b1, (k == 7), exp}) begin n_fail++; $display("FAIL drain_%0d: got v=%b d=%b %h expected v=1 d=%b %h", k, valid_out, done, data_out, (k == 7), exp); end
      end
      tick();
      n_chk++; if ({avail_out, overflow} !== 2'b11) begin n_fail++; $display("FAIL overflow_sticky: got avail=%b ovf=%b expected 11", avail_out, overflow); end
   endtask

   task automatic test_reset_midrun();
      logic bad = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      avail_in = 1'b0;
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd10;
      tick();
      configure = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_in = pack(8'(k+1), 8'(k+1), 8'(k+2), 8'(k+2)); valid_in = 1'b1;
         tick();
      end
      valid_in = 1'b0;
      avail_in = 1'b1;
      tick();
      avail_in = 1'b0;
      n_chk++; if ({valid_out, data_out} !== {1'b1, 32'h00000201}) begin n_fail++; $display("FAIL midrun_first: got v=%b %h expected v=1 00000201", valid_out, data_out); end
      rst = 1'b0;
      tick();
      n_chk++; if ({valid_out, done, overflow, data_out, idx_map, num_unique} !== 46'h0) begin n_fail++; $display("FAIL midrun_reset: got v=%b d=%b o=%b %h/%h/%0d expected all 0", valid_out, done, overflow, data_out, idx_map, num_unique); end
      rst = 1'b1;
      avail_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done !== 1'b0 || valid_out !== 1'b0 || avail_out !== 1'b1) bad = 1'b1;
      end
      n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midrun_quiet: got %b expected 0", bad); end
      data_in = pack(8'd1, 8'd1, 8'd1, 8'd1); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      configure = 1'b1; num_iters = 16'd0; num_reads_per_iter = 16'd5;
      tick();
      configure = 1'b0;
      n_chk++; if ({done, valid_out} !== 2'b10) begin n_fail++; $display("FAIL zero_cfg_done: got d=%b v=%b expected d=1 v=0", done, valid_out); end
      tick();
      n_chk++; if ({done, valid_out} !== 2'b00) begin n_fail++; $display("FAIL zero_cfg_after: got d=%b v=%b expected d=0 v=0", done, valid_out); end
      tick();
      n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL zero_cfg_no_pop: got %b expected 0", valid_out); end
   endtask

   initial begin
      rst = 1'b0; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
      bypass = 1'b0; data_in = '0; valid_in = 1'b0; avail_in = 1'b0;
      test_reset();
      test_basic();
      test_dedup();
      test_multi_iter();
      test_bypass();
      test_overflow();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
